// File: rtl/param_serializer_pkg.sv
// Shared definitions for the parallel-to-serial converter.
//   DATA_WIDTH_DEF : default word width
//   state_t        : serializer FSM states (IDLE, SHIFT)
//   sel_out_bit    : picks the output-end bit of a word for a given bit order
package serializer_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Output end is the MSB when serialising MSB-first, else the LSB.
    function automatic logic sel_out_bit(input logic [63:0] word, input logic msb_first,
                                         input int width);
        return msb_first ? word[width-1] : word[0];
    endfunction

endpackage

// File: rtl/param_serializer_if.sv
// Handshake/bus bundle between a word producer and param_serializer.
//   data_in, load, enable, msb_first : producer -> serializer
//   data_out, busy, done             : serializer -> producer
//   parity_out                       : serializer -> producer (PARAM_SERIALIZER_PARITY_EN only)
// Modports: master (producer side), slave (serializer side).
interface param_serializer_if
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  load;
    logic                  enable;
    logic                  msb_first;
    logic                  data_out;
    logic                  busy;
    logic                  done;
`ifdef PARAM_SERIALIZER_PARITY_EN
    logic                  parity_out;

    modport master (output data_in, load, enable, msb_first,
                    input  data_out, busy, done, parity_out);
    modport slave  (input  data_in, load, enable, msb_first,
                    output data_out, busy, done, parity_out);
`else
    modport master (output data_in, load, enable, msb_first,
                    input  data_out, busy, done);
    modport slave  (input  data_in, load, enable, msb_first,
                    output data_out, busy, done);
`endif
endinterface

// File: rtl/param_serializer_parity.sv
// parity_calc: combinational even-parity (XOR reduction) of a DATA_WIDTH word.
//   data   : input word
//   parity : XOR of all bits of data
// Only instantiated when PARAM_SERIALIZER_PARITY_EN is defined.
module parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  parity
);
    assign parity = ^data;
endmodule

// File: rtl/param_serializer.sv
// param_serializer: loads a DATA_WIDTH word and shifts it out one bit per
// enabled cycle, LSB- or MSB-first as chosen at load time.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : param_serializer_if.slave (data_in, load, enable, msb_first ->
//         data_out, busy, done [, parity_out])
// Optional feature macro: PARAM_SERIALIZER_PARITY_EN adds bus.parity_out,
// the XOR of the word captured at the last accepted load.
module param_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    param_serializer_if.slave    bus
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  shift_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   order;      // captured msb_first
    logic                   data_out_r;
    logic                   done_r;

    // Move the word one position toward its output end; vacated bits fill with 0.
    always_comb begin
        shift_nxt = order ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                          : {1'b0, shift_reg[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            cnt        <= '0;
            order      <= 1'b0;
            data_out_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shift_reg  <= bus.data_in;
                        order      <= bus.msb_first;
                        cnt        <= '0;
                        // First bit is visible the cycle after acceptance.
                        data_out_r <= sel_out_bit(64'(bus.data_in), bus.msb_first, DATA_WIDTH);
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // load is ignored throughout SHIFT, including the last-bit cycle.
                    if (bus.enable) begin
                        if (cnt == LAST) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            data_out_r <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            shift_reg  <= shift_nxt;
                            cnt        <= cnt + CNT_WIDTH'(1);
                            data_out_r <= sel_out_bit(64'(shift_nxt), order, DATA_WIDTH);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_r;

`ifdef PARAM_SERIALIZER_PARITY_EN
    logic parity_w;
    logic parity_r;

    parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data   (bus.data_in),
        .parity (parity_w)
    );

    // Parity tracks the accepted word only; held until the next accepted load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_r <= 1'b0;
        end else if (state == IDLE && bus.load) begin
            parity_r <= parity_w;
        end
    end

    assign bus.parity_out = parity_r;
`endif

endmodule

// File: tb/tb_param_serializer.sv
// Directed, table-driven bench for param_serializer (DATA_WIDTH=8), plus
// hand-written sequences for enable stalls, ignored loads, back-to-back
// loads and mid-word reset. Parity is exercised on a 16-bit instance when
// PARAM_SERIALIZER_PARITY_EN is defined.
module tb_param_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    param_serializer_if #(.DATA_WIDTH(8)) bus ();

    param_serializer #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PARAM_SERIALIZER_PARITY_EN
    param_serializer_if #(.DATA_WIDTH(16)) bus16 ();

    param_serializer #(.DATA_WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );
`endif

    // seq holds the expected serial stream in time order, first bit leftmost.
    typedef struct {
        logic [7:0] data;
        logic       msb;
        logic [7:0] seq;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Called with the DUT idle, just after a clock edge.
    task automatic run_word(input logic [7:0] data, input logic msb, input logic [7:0] seq,
                            input string nm);
        bus.data_in   = data;
        bus.msb_first = msb;
        bus.load      = 1'b1;
        bus.enable    = 1'b1;
        tick();
        bus.load      = 1'b0;
        // Disturb the inputs mid-word; the word in flight must not change.
        bus.data_in   = ~data;
        bus.msb_first = ~msb;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("%s bit%0d", nm, i), 32'(bus.data_out), 32'(seq[7-i]));
            chk($sformatf("%s busy%0d", nm, i), 32'(bus.busy), 32'd1);
            chk($sformatf("%s nodone%0d", nm, i), 32'(bus.done), 32'd0);
        end
        tick();
        chk({nm, " done"}, 32'(bus.done), 32'd1);
        chk({nm, " idle"}, 32'(bus.busy), 32'd0);
        chk({nm, " out0"}, 32'(bus.data_out), 32'd0);
        tick();
        chk({nm, " done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, msb: 1'b0, seq: 8'b10100101};
        vecs[1] = '{data: 8'hA5, msb: 1'b1, seq: 8'b10100101};
        vecs[2] = '{data: 8'h01, msb: 1'b1, seq: 8'b00000001};
        vecs[3] = '{data: 8'h3C, msb: 1'b0, seq: 8'b00111100};
        vecs[4] = '{data: 8'h80, msb: 1'b0, seq: 8'b00000001};
        vecs[5] = '{data: 8'hC1, msb: 1'b1, seq: 8'b11000001};
        vecs[6] = '{data: 8'hC1, msb: 1'b0, seq: 8'b10000011};

        bus.data_in = '0; bus.load = 1'b0; bus.enable = 1'b0; bus.msb_first = 1'b0;
`ifdef PARAM_SERIALIZER_PARITY_EN
        bus16.data_in = '0; bus16.load = 1'b0; bus16.enable = 1'b0; bus16.msb_first = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst data_out", 32'(bus.data_out), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        rst = 1'b1;
        tick();

        // Table of whole words
        for (int v = 0; v < 7; v++)
            run_word(vecs[v].data, vecs[v].msb, vecs[v].seq, $sformatf("vec%0d", v));

        // Enable stall: 0x3C LSB-first, freeze 3 cycles after bit index 2
        bus.data_in = 8'h3C; bus.msb_first = 1'b0; bus.load = 1'b1; bus.enable = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("stall bit%0d", i), 32'(bus.data_out), 32'(vecs[3].seq[7-i]));
            if (i == 2) begin
                bus.enable = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk($sformatf("stall hold%0d", k), 32'(bus.data_out), 32'd1);
                    chk($sformatf("stall busy%0d", k), 32'(bus.busy), 32'd1);
                    chk($sformatf("stall nodone%0d", k), 32'(bus.done), 32'd0);
                end
                bus.enable = 1'b1;
            end
        end
        tick();
        chk("stall done", 32'(bus.done), 32'd1);
        tick();
        chk("stall done_pulse", 32'(bus.done), 32'd0);

        // Ignored loads at bits 4 and 7, then accepted load in the done cycle
        bus.data_in = 8'hFF; bus.msb_first = 1'b0; bus.load = 1'b1; bus.enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            bus.load = 1'b0;
            chk($sformatf("ign bit%0d", i), 32'(bus.data_out), 32'd1);
            chk($sformatf("ign busy%0d", i), 32'(bus.busy), 32'd1);
            if (i == 4 || i == 7) begin
                bus.load    = 1'b1;
                bus.data_in = 8'h00;
            end
        end
        tick();
        chk("ign done", 32'(bus.done), 32'd1);
        chk("ign idle", 32'(bus.busy), 32'd0);
        bus.load = 1'b1; bus.data_in = 8'h00;
        tick();
        bus.load = 1'b0;
        chk("b2b busy", 32'(bus.busy), 32'd1);
        chk("b2b bit0", 32'(bus.data_out), 32'd0);
        chk("b2b nodone", 32'(bus.done), 32'd0);
        repeat (8) tick();
        chk("b2b done", 32'(bus.done), 32'd1);
        tick();

        // Mid-word reset at bit index 5
        bus.data_in = 8'hA5; bus.msb_first = 1'b0; bus.load = 1'b1; bus.enable = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (5) tick();
        chk("mrst pre bit5", 32'(bus.data_out), 32'd1);
        rst = 1'b0;
        #1;
        chk("mrst busy", 32'(bus.busy), 32'd0);
        chk("mrst data_out", 32'(bus.data_out), 32'd0);
        chk("mrst done", 32'(bus.done), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst no done", 32'(bus.done), 32'd0);
        chk("mrst idle", 32'(bus.busy), 32'd0);
        run_word(8'hC1, 1'b1, 8'b11000001, "post_rst");

`ifdef PARAM_SERIALIZER_PARITY_EN
        bus16.data_in = 16'h0007; bus16.load = 1'b1; bus16.enable = 1'b1;
        tick();
        bus16.load = 1'b0;
        chk("par 0007", 32'(bus16.parity_out), 32'd1);
        repeat (16) tick();
        chk("par done", 32'(bus16.done), 32'd1);
        chk("par hold", 32'(bus16.parity_out), 32'd1);
        bus16.data_in = 16'h0003; bus16.load = 1'b1;
        tick();
        bus16.load = 1'b0;
        chk("par 0003", 32'(bus16.parity_out), 32'd0);
        repeat (17) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
